subtractor_32bit_serial: RTL and testbench

// - Byte-serial 32-bit unsigned subtractor: diff = a - b, plus borrow flag; inverse of the 32-bit adder datapath.
// - Reuses one 8-bit subtract slice over 4 cycles, LSB byte first; trades latency for area.
// - Sits beside the adder tree in the arithmetic unit; valid/ready on both sides so it can be stalled.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/subtractor_32bit_serial_if.sv | 33 +++
 rtl/subtractor_8bit.sv | 24 ++
 rtl/subtractor_32bit_serial.sv | 100 ++++++++++
 tb/tb_subtractor_32bit_serial.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
// Provides the serial FSM state type, the slice width, the default
// datapath width and a helper for sizing the slice index counter.
package arith_pkg;

  localparam int SLICE_W       = 8;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter addressing n slices; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/subtractor_32bit_serial_if.sv
// Operand/result handshake bundle for the serial subtractor.
// Signals:
//   in_valid/in_ready   operand handshake (producer -> subtractor)
//   a, b                minuend and subtrahend
//   out_valid/out_ready result handshake (subtractor -> consumer)
//   diff, borrow_out    a - b modulo 2^WIDTH and unsigned borrow
// Modports: master = producer/consumer side, slave = subtractor side.
interface subtractor_32bit_serial_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out
  );

endinterface

// File: rtl/subtractor_8bit.sv
// Combinational subtract slice: {borrow_out, diff} = a - b - borrow_in.
// Ports:
//   a, b        slice operands (W bits, unsigned)
//   borrow_in   borrow from the next-lower slice
//   diff        slice difference
//   borrow_out  borrow into the next-higher slice
module subtractor_8bit
  import arith_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  // Extended by one bit so the wrap-around lands in the borrow position.
  always_comb begin
    {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
  end

endmodule

// File: rtl/subtractor_32bit_serial.sv
// Byte-serial unsigned subtractor: diff = a - b, borrow_out = (a < b).
// One subtract slice is reused over NSLICE cycles, LSB slice first.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    handshake bundle (slave side): in_valid/in_ready, a, b,
//          out_valid/out_ready, diff, borrow_out
// Flow: IDLE accepts operands, CALC runs NSLICE slice steps, DONE holds
// the result until out_ready. Operands are never accepted outside IDLE.
module subtractor_32bit_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = SLICE_W
) (
  input logic                     clk,
  input logic                     rst_n,
  subtractor_32bit_serial_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borrow_out;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_d_slice;
  logic             w_bo;

  assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

  subtractor_8bit #(
    .W (SLICE)
  ) u_slice (
    .a          (w_a_slice),
    .b          (w_b_slice),
    .borrow_in  (r_borrow),
    .diff       (w_d_slice),
    .borrow_out (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a          <= bus.a;
            r_b          <= bus.b;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_diff[r_idx*SLICE +: SLICE] <= w_d_slice;
          r_borrow                     <= w_bo;
          if (r_idx == LAST_IDX) begin
            // Final slice: its borrow is the borrow of the whole word.
            r_borrow_out <= w_bo;
            r_idx        <= '0;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Self-checking bench for subtractor_32bit_serial: directed corner pairs,
// random pairs with backpressure, reset mid-operation and a streaming run.
module tb_subtractor_32bit_serial;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;

  subtractor_32bit_serial_if #(.WIDTH(32)) bus ();

  subtractor_32bit_serial #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        br;
    int          c;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One complete transaction. in_valid stays high with junk operands while
  // the block is busy, which must be ignored and must not disturb the result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] e_d;
    logic        e_br;
    bit          ok;
    int          lat;
    e_d  = a - b;
    e_br = (a < b);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
    chk("diff", 64'(bus.diff), 64'(e_d));
    chk("borrow", 64'(bus.borrow_out), 64'(e_br));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_diff", 64'(bus.diff), 64'(e_d));
      chk("hold_borrow", 64'(bus.borrow_out), 64'(e_br));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("handoff_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("diff_kept", 64'(bus.diff), 64'(e_d));
    chk("borrow_kept", 64'(bus.borrow_out), 64'(e_br));
  endtask

  initial begin
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    bit          acc;
    bit          hand;
    int          n_acc;
    int          n_done;
    int          cyc;
    exp_t        e;

    n_checks = 0;
    n_pass   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_borrow", 64'(bus.borrow_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    ta[0] = 32'h0000_0010; tb[0] = 32'h0000_0001;
    ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001;
    ta[2] = 32'h0100_0000; tb[2] = 32'h0000_0001;
    ta[3] = 32'hDEAD_BEEF; tb[3] = 32'hDEAD_BEEF;
    ta[4] = 32'hFFFF_FFFF; tb[4] = 32'h0000_0000;
    ta[5] = 32'h8000_0000; tb[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) do_op(ta[i], tb[i], 0);

    do_op(32'h1234_5678, 32'h8765_4321, 10);

    for (int i = 0; i < 20; i++) begin
      do_op($urandom, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while the third slice is pending.
    bus.a        = 32'h1234_5678;
    bus.b        = 32'h0000_0001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_diff", 64'(bus.diff), 64'd0);
    chk("midrst_borrow", 64'(bus.borrow_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(32'd5, 32'd3, 0);

    // Streaming: producer and consumer always ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = $urandom;
    bus.b = $urandom;
    n_acc  = 0;
    n_done = 0;
    cyc    = 0;
    while (n_done < 100 && cyc < 2000) begin
      acc  = bus.in_valid && bus.in_ready;
      hand = bus.out_valid && bus.out_ready;
      chk("overlap", 64'(bus.in_ready & bus.out_valid), 64'd0);
      if (hand) begin
        if (q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("b2b_diff", 64'(bus.diff), 64'(e.d));
          chk("b2b_borrow", 64'(bus.borrow_out), 64'(e.br));
          chk("b2b_latency", 64'(cyc - e.c), 64'd5);
        end
        n_done++;
      end
      if (acc) begin
        e.d  = bus.a - bus.b;
        e.br = (bus.a < bus.b);
        e.c  = cyc;
        q.push_back(e);
        n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (n_acc == 100) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a = $urandom;
          bus.b = $urandom;
        end
      end
    end
    chk("b2b_count", 64'(n_done), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
